// File: rtl/data_ram_port.sv
// -----------------------------------------------------------------------------
// data_ram_port
//
// Word-addressed data RAM behind the memory control stage. A request seen in
// IDLE is captured into holding registers, the sequencer burns WAIT_STATES
// cycles, performs a single array access, and then pulses `done` for one
// cycle before returning to IDLE. While an access is in flight the upstream
// pipeline is frozen through `stall`.
//
// Parameters
//   DATA_W       word width
//   ADDR_W       word-address bits; the array holds 2**ADDR_W words
//   WAIT_STATES  extra cycles before the array access (0..15)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   mem_req      request qualifier, only looked at in IDLE
//   RW           1 = read, 0 = write candidate
//   str_enable   store qualifier; a write needs RW=0 and str_enable=1
//   address      32-bit word address; bits above ADDR_W must be zero
//   RAM_in       store data
//   RAM_out      registered read data, held until the next completed read
//   busy         registered, high whenever the sequencer is not in IDLE
//   done         one-cycle completion pulse
//   stall        combinational freeze request to the upstream pipeline
//   addr_err     one-cycle pulse alongside done for an out-of-range address
//   state_dbg    current sequencer state (IDLE=0, WAIT=1, ACCESS=2, DONE=3)
//
// Handshake: the upstream stage presents a request and keeps it steady for
// as long as `stall` is high. The request is accepted on the first rising
// edge where the sequencer is in IDLE and the request decodes to a valid
// read or write; `stall` is low again in the DONE cycle so upstream can
// advance there. A request still present when the sequencer is back in IDLE
// starts a fresh access.
// -----------------------------------------------------------------------------
module data_ram_port #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              RW,
  input  logic              str_enable,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] RAM_in,
  output logic [DATA_W-1:0] RAM_out,
  output logic              busy,
  output logic              done,
  output logic              stall,
  output logic              addr_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  // ---------------------------------------------------------------------------
  // State and holding registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [3:0]          cnt_q,   cnt_d;
  logic                op_rd_q, op_rd_d;   // captured op: 1 = read, 0 = write
  logic [ADDR_W-1:0]   addr_q,  addr_d;
  logic                oor_q,   oor_d;     // captured out-of-range flag
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                busy_q,  busy_d;
  logic                done_q,  done_d;
  logic                err_q,   err_d;

  // Storage array; contents are deliberately not reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic req_rd;
  logic req_wr;
  logic req_valid;
  logic addr_oor;
  logic mem_we;

  assign req_rd    = mem_req && RW;
  assign req_wr    = mem_req && !RW && str_enable;
  assign req_valid = req_rd || req_wr;

  // Any set bit above the array index means the word does not exist.
  if (ADDR_W < 32) begin : g_range
    assign addr_oor = |address[31:ADDR_W];
  end else begin : g_full
    assign addr_oor = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_rd_d = req_rd;
          addr_d  = address[ADDR_W-1:0];
          oor_d   = addr_oor;
          wdata_d = RAM_in;
          cnt_d   = WAIT_LOAD;
          // With no wait states the access happens on the very next edge.
          state_d = (WAIT_LOAD == 4'd0) ? ST_ACCESS : ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Leaving at a count of 1 gives exactly WAIT_STATES cycles in WAIT.
        // The <= guard keeps the sequencer from wrapping if the count were
        // ever zero here.
        if (cnt_q <= 4'd1) begin
          state_d = ST_ACCESS;
        end
      end

      ST_ACCESS: begin
        if (op_rd_q) begin
          rdata_d = oor_q ? '0 : mem[addr_q];
        end
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with
    // the state they describe.
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_DONE) && oor_q;
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      op_rd_q <= 1'b0;
      addr_q  <= '0;
      oor_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
      addr_q  <= addr_d;
      oor_q   <= oor_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Array write port. Only the ACCESS state can write, so a reset that pulls
  // the sequencer back to IDLE before ACCESS cancels the store.
  // ---------------------------------------------------------------------------
  assign mem_we = (state_q == ST_ACCESS) && !op_rd_q && !oor_q;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Upstream is held in WAIT and ACCESS, and in IDLE while a valid request is
  // waiting to be taken; it is released in the DONE cycle.
  assign stall = ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                 ((state_q == ST_IDLE) && req_valid);

  assign RAM_out   = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_data_ram_port.sv
// -----------------------------------------------------------------------------
// tb_data_ram_port
//
// Three instances of data_ram_port with WAIT_STATES of 1, 4 and 0 share one
// clock and have independent inputs and resets. A behavioural model (an
// associative array of written words plus the last value read per instance)
// supplies every expected value; access latency is expected to be
// WAIT_STATES+2 cycles from the acceptance edge to the done cycle.
// -----------------------------------------------------------------------------
module tb_data_ram_port;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int N_DUT  = 3;

  function automatic int ws_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Clock and DUT signals
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n     [N_DUT];
  logic              mem_req   [N_DUT];
  logic              rw_s      [N_DUT];
  logic              str_s     [N_DUT];
  logic [31:0]       address   [N_DUT];
  logic [DATA_W-1:0] ram_in    [N_DUT];
  logic [DATA_W-1:0] ram_out   [N_DUT];
  logic              busy      [N_DUT];
  logic              done      [N_DUT];
  logic              stall     [N_DUT];
  logic              addr_err  [N_DUT];
  logic [1:0]        state_dbg [N_DUT];

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    data_ram_port #(
      .DATA_W      (DATA_W),
      .ADDR_W      (ADDR_W),
      .WAIT_STATES (ws_of(g))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .mem_req    (mem_req[g]),
      .RW         (rw_s[g]),
      .str_enable (str_s[g]),
      .address    (address[g]),
      .RAM_in     (ram_in[g]),
      .RAM_out    (ram_out[g]),
      .busy       (busy[g]),
      .done       (done[g]),
      .stall      (stall[g]),
      .addr_err   (addr_err[g]),
      .state_dbg  (state_dbg[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard counters
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] mdl     [int];
  logic [DATA_W-1:0] last_rd [N_DUT];

  function automatic int key(input int d, input logic [31:0] a);
    return d * 4096 + int'(a[ADDR_W-1:0]);
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: present one request, drop it right after acceptance and scramble
  // the data/address/RW lines so late changes would show up as corruption.
  // Observes the completion cycle within a bounded window.
  // ---------------------------------------------------------------------------
  task automatic run_access(input int d, input bit rd_op, input bit str,
                            input logic [31:0] a, input logic [DATA_W-1:0] data,
                            output int lat, output logic [DATA_W-1:0] rdata,
                            output bit err, output bit stall_done,
                            output int stray, output int busy_low);
    lat = -1; rdata = '0; err = 1'b0; stall_done = 1'b1; stray = 0; busy_low = 0;
    @(negedge clk);
    mem_req[d] = 1'b1; rw_s[d] = rd_op; str_s[d] = str;
    address[d] = a;    ram_in[d] = data;
    @(posedge clk);
    #1;
    mem_req[d] = 1'b0;
    rw_s[d]    = 1'($urandom);
    address[d] = $urandom;
    ram_in[d]  = $urandom;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!busy[d]) busy_low++;
      if (done[d]) begin
        lat = n; rdata = ram_out[d]; err = addr_err[d]; stall_done = stall[d];
        break;
      end
      if (addr_err[d]) stray++;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    for (int d = 0; d < N_DUT; d++) begin
      rst_n[d] = 1'b0; mem_req[d] = 1'b0; rw_s[d] = 1'b0; str_s[d] = 1'b0;
      address[d] = '0; ram_in[d] = '0; last_rd[d] = '0;
    end
    #12;
    for (int d = 0; d < N_DUT; d++) begin
      checks++; if (ram_out[d] !== '0) begin failures++; $display("FAIL reset_ram_out[%0d] got=%h exp=0", d, ram_out[d]); end
      checks++; if (busy[d] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d] got=%b exp=0 state=%0d", d, busy[d], state_dbg[d]); end
      checks++; if (done[d] !== 1'b0) begin failures++; $display("FAIL reset_done[%0d] got=%b exp=0", d, done[d]); end
      checks++; if (addr_err[d] !== 1'b0) begin failures++; $display("FAIL reset_addr_err[%0d] got=%b exp=0", d, addr_err[d]); end
      checks++; if (stall[d] !== 1'b0) begin failures++; $display("FAIL reset_stall[%0d] got=%b exp=0", d, stall[d]); end
    end
    @(negedge clk);
    for (int d = 0; d < N_DUT; d++) rst_n[d] = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat, stray, bl; logic [DATA_W-1:0] rd; bit err, sd;
    run_access(0, 1'b0, 1'b1, 32'h05, 32'hDEADBEEF, lat, rd, err, sd, stray, bl);
    mdl[key(0, 32'h05)] = 32'hDEADBEEF;
    checks++; if (lat !== ws_of(0) + 2) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, ws_of(0) + 2); end
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL wr_stall_in_done got=%b exp=0", sd); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL wr_busy_gaps got=%0d exp=0", bl); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wr_addr_err got=%b exp=0", err); end
    checks++; if (rd !== last_rd[0]) begin failures++; $display("FAIL wr_ram_out_held got=%h exp=%h", rd, last_rd[0]); end

    run_access(0, 1'b1, 1'b0, 32'h05, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (lat !== ws_of(0) + 2) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, ws_of(0) + 2); end
    checks++; if (rd !== mdl[key(0, 32'h05)]) begin failures++; $display("FAIL rd_data got=%h exp=%h", rd, mdl[key(0, 32'h05)]); end
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL rd_stall_in_done got=%b exp=0", sd); end
    last_rd[0] = mdl[key(0, 32'h05)];
  endtask

  task automatic test_noop;
    int lat, stray, bl; logic [DATA_W-1:0] rd; bit err, sd;
    @(negedge clk);
    mem_req[0] = 1'b1; rw_s[0] = 1'b0; str_s[0] = 1'b0; address[0] = 32'h05; ram_in[0] = $urandom;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      checks++;
      if ({busy[0], stall[0], done[0]} !== 3'b000) begin
        failures++; $display("FAIL noop_quiet cycle=%0d got busy/stall/done=%b%b%b exp=000", n, busy[0], stall[0], done[0]);
      end
    end
    mem_req[0] = 1'b0;
    run_access(0, 1'b1, 1'b0, 32'h05, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd !== mdl[key(0, 32'h05)]) begin failures++; $display("FAIL noop_readback got=%h exp=%h", rd, mdl[key(0, 32'h05)]); end
    last_rd[0] = mdl[key(0, 32'h05)];
  endtask

  task automatic test_out_of_range;
    int lat, stray, bl; logic [DATA_W-1:0] rd; bit err, sd;
    run_access(0, 1'b0, 1'b1, 32'h00, 32'hCAFEF00D, lat, rd, err, sd, stray, bl);
    mdl[key(0, 32'h00)] = 32'hCAFEF00D;
    run_access(0, 1'b0, 1'b1, 32'h100, 32'h12345678, lat, rd, err, sd, stray, bl);
    checks++; if (lat !== ws_of(0) + 2) begin failures++; $display("FAIL oor_wr_latency got=%0d exp=%0d", lat, ws_of(0) + 2); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_wr_addr_err got=%b exp=1", err); end
    checks++; if (stray !== 0) begin failures++; $display("FAIL oor_wr_err_outside_done got=%0d exp=0", stray); end
    checks++; if (rd !== last_rd[0]) begin failures++; $display("FAIL oor_wr_ram_out_held got=%h exp=%h", rd, last_rd[0]); end

    run_access(0, 1'b1, 1'b0, 32'h00, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd === 32'h12345678) begin failures++; $display("FAIL oor_alias got=%h exp=not 12345678", rd); end
    checks++; if (rd !== mdl[key(0, 32'h00)]) begin failures++; $display("FAIL oor_addr0_data got=%h exp=%h", rd, mdl[key(0, 32'h00)]); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL oor_addr0_err got=%b exp=0", err); end
    last_rd[0] = mdl[key(0, 32'h00)];

    run_access(0, 1'b1, 1'b0, 32'h100, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd !== '0) begin failures++; $display("FAIL oor_rd_data got=%h exp=0", rd); end
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL oor_rd_addr_err got=%b exp=1", err); end
    last_rd[0] = '0;
  endtask

  // Request held for n_hold edges: acceptances are WAIT_STATES+3 edges apart
  // and each completes WAIT_STATES+1 edges after its acceptance.
  task automatic test_held_request(input int d, input logic [31:0] a);
    int n_hold, ws, acc, idx;
    int exp_q[$];
    int seen_q[$];
    n_hold = 10;
    ws     = ws_of(d);
    acc    = 0;
    while (acc <= n_hold - 1) begin
      exp_q.push_back(acc + ws + 1);
      acc += ws + 3;
    end
    @(negedge clk);
    mem_req[d] = 1'b1; rw_s[d] = 1'b1; str_s[d] = 1'b0; address[d] = a; ram_in[d] = $urandom;
    for (int n = 0; n < n_hold + ws + 4; n++) begin
      @(posedge clk);
      #1;
      if (n == n_hold - 1) mem_req[d] = 1'b0;
      ram_in[d] = $urandom;
      @(negedge clk);
      if (done[d]) begin
        seen_q.push_back(n);
        checks++; if (ram_out[d] !== mdl[key(d, a)]) begin failures++; $display("FAIL held_data[%0d] cycle=%0d got=%h exp=%h", d, n, ram_out[d], mdl[key(d, a)]); end
        checks++; if (stall[d] !== 1'b0) begin failures++; $display("FAIL held_stall_in_done[%0d] cycle=%0d got=%b exp=0", d, n, stall[d]); end
      end
    end
    checks++;
    if (seen_q.size() !== exp_q.size()) begin
      failures++; $display("FAIL held_count[%0d] got=%0d exp=%0d", d, seen_q.size(), exp_q.size());
    end else begin
      for (idx = 0; idx < exp_q.size(); idx++) begin
        checks++; if (seen_q[idx] !== exp_q[idx]) begin failures++; $display("FAIL held_done_cycle[%0d] n=%0d got=%0d exp=%0d", d, idx, seen_q[idx], exp_q[idx]); end
      end
    end
    last_rd[d] = mdl[key(d, a)];
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait;
    int lat, stray, bl; logic [DATA_W-1:0] rd; bit err, sd;
    run_access(1, 1'b0, 1'b1, 32'h07, 32'h11111111, lat, rd, err, sd, stray, bl);
    mdl[key(1, 32'h07)] = 32'h11111111;
    checks++; if (lat !== ws_of(1) + 2) begin failures++; $display("FAIL ws4_wr_latency got=%0d exp=%0d", lat, ws_of(1) + 2); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL ws4_busy_gaps got=%0d exp=0", bl); end
    run_access(1, 1'b1, 1'b0, 32'h07, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd !== 32'h11111111) begin failures++; $display("FAIL ws4_pre_rd got=%h exp=11111111", rd); end
    last_rd[1] = 32'h11111111;

    @(negedge clk);
    mem_req[1] = 1'b1; rw_s[1] = 1'b0; str_s[1] = 1'b1; address[1] = 32'h07; ram_in[1] = 32'hAAAA5555;
    @(posedge clk);
    #1;
    mem_req[1] = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (busy[1] !== 1'b1 || stall[1] !== 1'b1) begin failures++; $display("FAIL midwait_inflight got busy/stall=%b%b exp=11", busy[1], stall[1]); end
    #1;
    rst_n[1] = 1'b0;
    #1;
    checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL midwait_busy got=%b exp=0", busy[1]); end
    checks++; if (stall[1] !== 1'b0) begin failures++; $display("FAIL midwait_stall got=%b exp=0", stall[1]); end
    checks++; if (done[1] !== 1'b0 || addr_err[1] !== 1'b0) begin failures++; $display("FAIL midwait_done_err got=%b%b exp=00", done[1], addr_err[1]); end
    checks++; if (ram_out[1] !== '0) begin failures++; $display("FAIL midwait_ram_out got=%h exp=0", ram_out[1]); end
    @(negedge clk);
    rst_n[1] = 1'b1;
    last_rd[1] = '0;
    repeat (8) @(negedge clk);

    run_access(1, 1'b1, 1'b0, 32'h07, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd !== mdl[key(1, 32'h07)]) begin failures++; $display("FAIL midwait_write_dropped got=%h exp=%h", rd, mdl[key(1, 32'h07)]); end
    run_access(1, 1'b0, 1'b1, 32'h07, 32'h1, lat, rd, err, sd, stray, bl);
    mdl[key(1, 32'h07)] = 32'h1;
    run_access(1, 1'b1, 1'b0, 32'h07, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL midwait_rewrite got=%h exp=1", rd); end
    checks++; if (lat !== ws_of(1) + 2) begin failures++; $display("FAIL ws4_rd_latency got=%0d exp=%0d", lat, ws_of(1) + 2); end
    last_rd[1] = 32'h1;
  endtask

  task automatic test_ws0;
    int lat, stray, bl; logic [DATA_W-1:0] rd, wd; bit err, sd;
    wd = $urandom;
    run_access(2, 1'b0, 1'b1, 32'h33, wd, lat, rd, err, sd, stray, bl);
    mdl[key(2, 32'h33)] = wd;
    checks++; if (lat !== 2) begin failures++; $display("FAIL ws0_wr_latency got=%0d exp=2", lat); end
    run_access(2, 1'b1, 1'b0, 32'h33, $urandom, lat, rd, err, sd, stray, bl);
    checks++; if (lat !== 2) begin failures++; $display("FAIL ws0_rd_latency got=%0d exp=2", lat); end
    checks++; if (rd !== wd) begin failures++; $display("FAIL ws0_rd_data got=%h exp=%h", rd, wd); end
    checks++; if (bl !== 0) begin failures++; $display("FAIL ws0_busy_gaps got=%0d exp=0", bl); end
    last_rd[2] = wd;
  endtask

  task automatic test_random(input int d);
    int lat, stray, bl, exp_lat;
    logic [DATA_W-1:0] rd, wd, exp_rd;
    logic [31:0] a;
    bit err, sd, oor, do_rd;
    logic [31:0] wr_q[$];
    exp_lat = ws_of(d) + 2;
    for (int i = 0; i < 20; i++) begin
      oor   = ($urandom_range(0, 7) == 0);
      do_rd = (wr_q.size() > 0 || oor) && ($urandom_range(0, 1) == 1);
      if (oor)        a = {24'($urandom_range(1, 24'hFFFFFF)), 8'($urandom_range(0, 255))};
      else if (do_rd) a = wr_q[$urandom_range(0, wr_q.size() - 1)];
      else            a = 32'($urandom_range(0, 255));
      wd = $urandom;
      run_access(d, do_rd, do_rd ? 1'($urandom) : 1'b1, a, wd, lat, rd, err, sd, stray, bl);
      if (do_rd) exp_rd = oor ? '0 : mdl[key(d, a)];
      else       exp_rd = last_rd[d];
      checks++; if (lat !== exp_lat) begin failures++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", d, i, lat, exp_lat); end
      checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_ram_out[%0d] op=%0d addr=%h got=%h exp=%h", d, i, a, rd, exp_rd); end
      checks++; if (err !== oor) begin failures++; $display("FAIL rand_addr_err[%0d] op=%0d got=%b exp=%b", d, i, err, oor); end
      checks++; if (stray !== 0 || bl !== 0 || sd !== 1'b0) begin failures++; $display("FAIL rand_status[%0d] op=%0d stray=%0d busy_gaps=%0d stall_done=%b exp=0/0/0", d, i, stray, bl, sd); end
      if (do_rd) last_rd[d] = exp_rd;
      if (!do_rd && !oor) begin
        mdl[key(d, a)] = wd;
        wr_q.push_back(a);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and summary
  // ---------------------------------------------------------------------------
  initial begin
    test_reset;
    test_write_read;
    test_noop;
    test_out_of_range;
    test_held_request(0, 32'h05);
    test_reset_mid_wait;
    test_ws0;
    test_held_request(2, 32'h33);
    for (int d = 0; d < N_DUT; d++) test_random(d);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_ram_port.md
# data_ram_port

Word-addressed data RAM with a multi-cycle access sequencer, sitting directly downstream of the memory control stage. It consumes that stage's `address`, `RAM_in`, `RW` and `str_enable` outputs, performs the read or store against an internal synchronous array after a programmable number of wait states, and returns `RAM_out` to it. It also raises a pipeline stall while an access is in flight.

## Interface
- `DATA_W`, 32: word width.
- `ADDR_W`, 8: word-address bits; array depth is 2^ADDR_W words.
- `WAIT_STATES`, 1: extra cycles inserted before the array access; legal range 0..15.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_req` in 1: request qualifier; sampled only in IDLE.
- `RW` in 1: 1 = read, 0 = write candidate.
- `str_enable` in 1: store qualifier; a write occurs only when `RW`=0 and `str_enable`=1.
- `address` in 32: word address.
- `RAM_in` in DATA_W: store data.
- `RAM_out` out DATA_W: registered read data.
- `busy` out 1: FSM is not in IDLE.
- `done` out 1: one-cycle completion pulse.
- `stall` out 1: freeze request to the upstream pipeline.
- `addr_err` out 1: one-cycle pulse, coincident with `done`, flagging an out-of-range address.

## Operation
- **Request decode in IDLE:**
  - READ when `mem_req`=1 and `RW`=1.
  - WRITE when `mem_req`=1, `RW`=0 and `str_enable`=1.
  - Any other combination is a no-op: the FSM stays in IDLE and no outputs change.
- **States:** IDLE -> WAIT -> ACCESS -> DONE -> IDLE.
  - IDLE -> WAIT on a valid op. The op, `address[ADDR_W-1:0]`, the range flag (`address[31:ADDR_W]` != 0) and `RAM_in` are captured into holding registers. The counter is loaded with WAIT_STATES.
  - If WAIT_STATES=0, IDLE goes directly to ACCESS and WAIT is skipped.
  - WAIT decrements the counter each cycle and moves to ACCESS when the counter reaches 1.
  - ACCESS, write in range: `mem[addr] <= wdata`.
  - ACCESS, read in range: `RAM_out <= mem[addr]`.
  - ACCESS, out of range: the write is suppressed and a read loads `RAM_out <= 0`.
  - ACCESS -> DONE unconditionally.
  - DONE drives `done`=1 (and `addr_err`=1 if the captured range flag is set), then returns to IDLE.
- Inputs are ignored outside IDLE. The requester must hold its request under `stall`; a request still present when the FSM returns to IDLE starts a new access.
- `RAM_out` holds its value until the next completed read. Writes do not modify it.
- Array contents are not reset and are undefined until written. Benches write before reading.
- Read-after-write to the same address returns the new data, because accesses are strictly serialized.

## Timing
- **Reset values:**
  - State = IDLE; counter = 0.
  - `RAM_out` = 0; `busy` = 0; `done` = 0; `addr_err` = 0.
  - `stall` = 0 while `mem_req` is low.
- **Latency:** a request accepted at edge k puts the FSM in ACCESS after edge k+WAIT_STATES. `done` is high during the cycle after edge k+WAIT_STATES+1, i.e. WAIT_STATES+2 cycles after acceptance.
- Read data is valid on `RAM_out` in the same cycle `done` is high.
- `busy` is registered: high from the cycle after acceptance through the DONE cycle inclusive.
- `stall` is combinational: (state != IDLE && state != DONE) || (state == IDLE && valid op). Upstream therefore advances in the DONE cycle.
- Back-to-back accesses have a minimum spacing of WAIT_STATES+3 cycles between acceptances.
- **Reset mid-operation:** `rst_n` low in any state returns the FSM to IDLE immediately and clears `done`/`addr_err`.
  - A write not yet in ACCESS is not performed.
  - `RAM_out` returns to 0.
- `mem_req` high coincident with `rst_n` release is not accepted until the first edge with `rst_n` high.

## Test plan
- **Write then read, WAIT_STATES=1:**
  - Write `address`=0x05, `RAM_in`=0xDEADBEEF, `RW`=0, `str_enable`=1 -> `done` pulse 3 cycles after acceptance; `stall` drops in the DONE cycle.
  - Then read 0x05 with `RW`=1 -> `RAM_out`=0xDEADBEEF in the `done` cycle.
- **No-op filtering:** `mem_req`=1, `RW`=0, `str_enable`=0 held 5 cycles -> `busy`, `stall` and `done` stay 0. A following read of 0x05 still returns 0xDEADBEEF.
- **Out of range:** write `address`=0x100 (ADDR_W=8), data 0x12345678 -> `done` and `addr_err` pulse together. A read of 0x00 does not return 0x12345678. A read of 0x100 returns `RAM_out`=0 with `addr_err`=1.
- **Held request under stall:** keep read of 0x05 asserted for 10 cycles -> exactly one access per WAIT_STATES+3 cycles. `RAM_in` changes while busy have no effect.
- **Reset mid-WAIT (WAIT_STATES=4):** write 0x07=0xAAAA5555, pulse `rst_n` low in the second WAIT cycle -> all outputs return to reset values immediately. A later write of 0x07=0x1 then read of 0x07 returns 0x1.
- **WAIT_STATES=0:** read accepted at edge k -> `done` and valid `RAM_out` in the cycle following edge k+1, a 2-cycle latency.
